// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master round-robin Wishbone arbiter.
//   - Arbiter state encoding. The encoding doubles as the one-hot grant
//     vector: OWN0 -> 2'b01, OWN1 -> 2'b10, IDLE -> 2'b00.
//   - Default slave-response timeout (used only when WB_ARB_TIMEOUT_EN is
//     defined).
//   - Byte-select width derivation from the data width.
// ---------------------------------------------------------------------------
package wb_arb_pkg;

   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_OWN0 = 2'd1;
   localparam logic [1:0] STATE_OWN1 = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = STATE_IDLE,
      ST_OWN0 = STATE_OWN0,
      ST_OWN1 = STATE_OWN1
   } arb_state_e;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd255;

   // One select bit per byte lane.
   function automatic int unsigned sel_width(input int unsigned data_width);
      return data_width / 32'd8;
   endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// ---------------------------------------------------------------------------
// wb_arb_timeout
// Stall counter for the arbiter. Counts consecutive cycles in which the
// granted master has STB asserted and the slave has returned neither ACK nor
// ERR. On the TIMEOUT_CYCLES-th such cycle it raises expire_o for that cycle
// only and the count restarts from zero.
//
// Ports:
//   clk_i      wb clock
//   reset_n_i  synchronous active-low reset
//   active_i   an owner is granted and is driving STB this cycle
//   resp_i     slave ACK or ERR this cycle
//   expire_o   timeout pulse (combinational from the count)
// ---------------------------------------------------------------------------
module wb_arb_timeout
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic active_i,
   input  logic resp_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
   // Count holds the number of stalled cycles already completed, so the
   // current cycle is the last allowed one when the count equals LIMIT-1.
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(32'd1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             expire_s;

   // Next count and expiry decode.
   always_comb begin
      cnt_d    = '0;
      expire_s = 1'b0;
      if (active_i && !resp_i) begin
         if (cnt_q == LAST_C) begin
            expire_s = 1'b1;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + ONE_C;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = expire_s;

endmodule

// File: rtl/wb_arbiter_rr2.sv
// ---------------------------------------------------------------------------
// wb_arbiter_rr2
// Two-master / one-slave Wishbone classic arbiter with round-robin fairness.
// The grant is held for the owner's whole CYC, so bursts are never
// interleaved. Masters always pass through IDLE between owners, giving one
// cycle of arbitration latency and a one-cycle gap between owners.
//
// Ports:
//   i_clk, i_reset_n           wb clock, synchronous active-low reset
//   i_m{0,1}_cyc/stb/we/sel/adr/dat   master requests
//   o_m{0,1}_dat/ack/err       master responses (read data broadcast,
//                              ack/err only to the owner)
//   o_s_cyc/stb/we/sel/adr/dat slave request (owner's signals, 0 in IDLE)
//   i_s_dat/ack/err            slave response
//   o_grant                    one-hot owner, 00 = idle
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a slave that stalls STB for
// TIMEOUT_CYCLES cycles is cut off; the owner gets a one-cycle ERR, CYC/STB
// are forced low for that cycle and the bus returns to IDLE.
// ---------------------------------------------------------------------------
module wb_arbiter_rr2
   import wb_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32'd32,
   parameter int unsigned DATA_WIDTH     = 32'd32,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int unsigned SEL_WIDTH     = sel_width(DATA_WIDTH)
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_m0_cyc,
   input  logic                  i_m0_stb,
   input  logic                  i_m0_we,
   input  logic [SEL_WIDTH-1:0]  i_m0_sel,
   input  logic [ADDR_WIDTH-1:0] i_m0_adr,
   input  logic [DATA_WIDTH-1:0] i_m0_dat,
   output logic [DATA_WIDTH-1:0] o_m0_dat,
   output logic                  o_m0_ack,
   output logic                  o_m0_err,
   input  logic                  i_m1_cyc,
   input  logic                  i_m1_stb,
   input  logic                  i_m1_we,
   input  logic [SEL_WIDTH-1:0]  i_m1_sel,
   input  logic [ADDR_WIDTH-1:0] i_m1_adr,
   input  logic [DATA_WIDTH-1:0] i_m1_dat,
   output logic [DATA_WIDTH-1:0] o_m1_dat,
   output logic                  o_m1_ack,
   output logic                  o_m1_err,
   output logic                  o_s_cyc,
   output logic                  o_s_stb,
   output logic                  o_s_we,
   output logic [SEL_WIDTH-1:0]  o_s_sel,
   output logic [ADDR_WIDTH-1:0] o_s_adr,
   output logic [DATA_WIDTH-1:0] o_s_dat,
   input  logic [DATA_WIDTH-1:0] i_s_dat,
   input  logic                  i_s_ack,
   input  logic                  i_s_err,
   output logic [1:0]            o_grant
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       ptr_q;      // 0: m0 wins the next contention, 1: m1 wins
   logic       ptr_d;
   logic       own_cyc_s;
   logic       own_stb_s;
   logic       expire_s;
   logic       own0_s;
   logic       own1_s;

   // State and priority pointer registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic; the pointer only moves when both masters contend.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (i_m0_cyc && i_m1_cyc) begin
               if (ptr_q) begin
                  state_d = ST_OWN1;
               end else begin
                  state_d = ST_OWN0;
               end
               ptr_d = ~ptr_q;
            end else if (i_m0_cyc) begin
               state_d = ST_OWN0;
            end else if (i_m1_cyc) begin
               state_d = ST_OWN1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN0: begin
            if (!i_m0_cyc || expire_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OWN0;
            end
         end
         ST_OWN1: begin
            if (!i_m1_cyc || expire_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OWN1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request mux: owner's signals to the slave, all zero when idle.
   always_comb begin
      own_cyc_s = 1'b0;
      own_stb_s = 1'b0;
      o_s_we    = 1'b0;
      o_s_sel   = '0;
      o_s_adr   = '0;
      o_s_dat   = '0;
      case (state_q)
         ST_OWN0: begin
            own_cyc_s = i_m0_cyc;
            own_stb_s = i_m0_stb;
            o_s_we    = i_m0_we;
            o_s_sel   = i_m0_sel;
            o_s_adr   = i_m0_adr;
            o_s_dat   = i_m0_dat;
         end
         ST_OWN1: begin
            own_cyc_s = i_m1_cyc;
            own_stb_s = i_m1_stb;
            o_s_we    = i_m1_we;
            o_s_sel   = i_m1_sel;
            o_s_adr   = i_m1_adr;
            o_s_dat   = i_m1_dat;
         end
         default: begin
            own_cyc_s = 1'b0;
         end
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   wb_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (i_clk),
      .reset_n_i (i_reset_n),
      .active_i  (own_cyc_s & own_stb_s),
      .resp_i    (i_s_ack | i_s_err),
      .expire_o  (expire_s)
   );
`else
   // No timeout: wait for the slave indefinitely. The parameter is kept so
   // both builds share one instantiation interface.
   assign expire_s = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

   // A timeout cuts the cycle off at the slave for the error cycle.
   assign o_s_cyc = own_cyc_s & ~expire_s;
   assign o_s_stb = own_stb_s & ~expire_s;

   assign own0_s  = (state_q == ST_OWN0);
   assign own1_s  = (state_q == ST_OWN1);
   assign o_grant = {own1_s, own0_s};

   // Read data is broadcast; strobed responses only reach the owner, so a
   // stray slave ack while idle is dropped.
   assign o_m0_dat = i_s_dat;
   assign o_m1_dat = i_s_dat;
   assign o_m0_ack = own0_s & i_s_ack;
   assign o_m1_ack = own1_s & i_s_ack;
   assign o_m0_err = own0_s & (i_s_err | expire_s);
   assign o_m1_err = own1_s & (i_s_err | expire_s);

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_rr2
// Directed bench for wb_arbiter_rr2: reset, contention fairness, burst hold,
// data path, slave error, reset mid-transfer and (with WB_ARB_TIMEOUT_EN,
// TIMEOUT_CYCLES=16) the stall timeout. Inputs change on the falling edge,
// outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_rr2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_cyc, m0_stb, m0_we;
   logic [3:0]  m0_sel;
   logic [31:0] m0_adr, m0_wdat;
   logic [31:0] m0_rdat;
   logic        m0_ack, m0_err;
   logic        m1_cyc, m1_stb, m1_we;
   logic [3:0]  m1_sel;
   logic [31:0] m1_adr, m1_wdat;
   logic [31:0] m1_rdat;
   logic        m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_wdat;
   logic [31:0] s_rdat;
   logic        s_ack, s_err;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_arbiter_rr2 #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_m0_cyc  (m0_cyc),
      .i_m0_stb  (m0_stb),
      .i_m0_we   (m0_we),
      .i_m0_sel  (m0_sel),
      .i_m0_adr  (m0_adr),
      .i_m0_dat  (m0_wdat),
      .o_m0_dat  (m0_rdat),
      .o_m0_ack  (m0_ack),
      .o_m0_err  (m0_err),
      .i_m1_cyc  (m1_cyc),
      .i_m1_stb  (m1_stb),
      .i_m1_we   (m1_we),
      .i_m1_sel  (m1_sel),
      .i_m1_adr  (m1_adr),
      .i_m1_dat  (m1_wdat),
      .o_m1_dat  (m1_rdat),
      .o_m1_ack  (m1_ack),
      .o_m1_err  (m1_err),
      .o_s_cyc   (s_cyc),
      .o_s_stb   (s_stb),
      .o_s_we    (s_we),
      .o_s_sel   (s_sel),
      .o_s_adr   (s_adr),
      .o_s_dat   (s_wdat),
      .i_s_dat   (s_rdat),
      .i_s_ack   (s_ack),
      .i_s_err   (s_err),
      .o_grant   (grant)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_m0(input logic req);
      m0_cyc = req;
      m0_stb = req;
   endtask

   task automatic set_m1(input logic req);
      m1_cyc = req;
      m1_stb = req;
   endtask

   initial begin
      reset_n = 1'b0;
      m0_we = 1'b0; m0_sel = 4'hF; m0_adr = 32'h3000_1000; m0_wdat = 32'h0000_00A0;
      m1_we = 1'b0; m1_sel = 4'hF; m1_adr = 32'h3000_1000; m1_wdat = 32'h0000_00B0;
      set_m0(1'b1);
      set_m1(1'b1);
      s_rdat = 32'h0000_0000; s_ack = 1'b1; s_err = 1'b0;

      // Reset held 3 cycles with both masters requesting and a stray ack.
      @(negedge clk);
      repeat (3) tick();
      check_eq("rst_grant", grant, 32'd0);
      check_eq("rst_s_cyc", s_cyc, 32'd0);
      check_eq("rst_s_stb", s_stb, 32'd0);
      check_eq("rst_s_adr", s_adr, 32'd0);
      check_eq("rst_m0_ack", m0_ack, 32'd0);
      check_eq("rst_m1_ack", m1_ack, 32'd0);

      // First grant after release goes to m0.
      s_ack = 1'b0;
      reset_n = 1'b1;
      tick();
      check_eq("rel_grant", grant, 32'd1);
      check_eq("rel_s_cyc", s_cyc, 32'd1);
      check_eq("rel_s_adr", s_adr, 32'h3000_1000);

      // Contention: back-to-back single reads, 1-cycle slave ack.
      for (int r = 0; r < 4; r++) begin
         bit own1;
         own1 = r[0];
         check_eq("fair_grant", grant, own1 ? 32'd2 : 32'd1);
         s_ack = 1'b1;
         if (own1) set_m1(1'b0); else set_m0(1'b0);
         #1;
         check_eq("fair_ack_owner", own1 ? m1_ack : m0_ack, 32'd1);
         check_eq("fair_ack_other", own1 ? m0_ack : m1_ack, 32'd0);
         tick();
         s_ack = 1'b0;
         set_m0(1'b1);
         set_m1(1'b1);
         #1;
         check_eq("fair_gap", grant, 32'd0);
         tick();
      end
      check_eq("fair_wrap", grant, 32'd1);
      set_m0(1'b0);
      set_m1(1'b0);
      tick();
      check_eq("fair_idle", grant, 32'd0);

      // Burst: m0 holds CYC for 4 writes while m1 waits.
      m0_we = 1'b1; m0_adr = 32'h3000_0000;
      set_m0(1'b1);
      tick();
      check_eq("burst_grant0", grant, 32'd1);
      m1_adr = 32'h4000_0000;
      set_m1(1'b1);
      for (int k = 0; k < 4; k++) begin
         m0_adr = 32'h3000_0000 + 32'(4 * k);
         s_ack = 1'b1;
         if (k == 3) set_m0(1'b0);
         #1;
         check_eq("burst_adr", s_adr, 32'h3000_0000 + 32'(4 * k));
         check_eq("burst_grant", grant, 32'd1);
         check_eq("burst_m0_ack", m0_ack, 32'd1);
         check_eq("burst_m1_ack", m1_ack, 32'd0);
         tick();
      end
      s_ack = 1'b0;
      #1;
      check_eq("burst_gap", grant, 32'd0);
      tick();
      check_eq("burst_m1_grant", grant, 32'd2);
      check_eq("burst_m1_adr", s_adr, 32'h4000_0000);

      // Data path: m1 write then read.
      m1_we = 1'b1; m1_wdat = 32'hDEAD_BEEF; m1_sel = 4'b0011;
      #1;
      check_eq("dp_s_dat", s_wdat, 32'hDEAD_BEEF);
      check_eq("dp_s_sel", s_sel, 32'h0000_0003);
      check_eq("dp_s_we", s_we, 32'd1);
      s_ack = 1'b1;
      #1;
      check_eq("dp_wr_ack", m1_ack, 32'd1);
      tick();
      m1_we = 1'b0; s_rdat = 32'h1234_5678;
      set_m1(1'b0);
      #1;
      check_eq("dp_m1_rdat", m1_rdat, 32'h1234_5678);
      check_eq("dp_m0_rdat", m0_rdat, 32'h1234_5678);
      check_eq("dp_rd_ack", m1_ack, 32'd1);
      check_eq("dp_rd_m0_ack", m0_ack, 32'd0);
      tick();
      s_ack = 1'b0;
      #1;
      check_eq("dp_ack_1cyc", m1_ack, 32'd0);
      check_eq("dp_idle", grant, 32'd0);
      s_ack = 1'b1;
      #1;
      check_eq("stray_m0_ack", m0_ack, 32'd0);
      check_eq("stray_m1_ack", m1_ack, 32'd0);
      s_ack = 1'b0;

      // Slave error on an m0 access, m1 pending.
      m0_adr = 32'h3000_2000; m0_we = 1'b0;
      set_m0(1'b1);
      tick();
      check_eq("err_grant", grant, 32'd1);
      set_m1(1'b1);
      s_err = 1'b1;
      set_m0(1'b0);
      #1;
      check_eq("err_m0_err", m0_err, 32'd1);
      check_eq("err_m0_ack", m0_ack, 32'd0);
      check_eq("err_m1_err", m1_err, 32'd0);
      tick();
      s_err = 1'b0;
      #1;
      check_eq("err_1cyc", m0_err, 32'd0);
      check_eq("err_gap", grant, 32'd0);
      tick();
      check_eq("err_m1_grant", grant, 32'd2);

      // Reset asserted mid-transfer.
      check_eq("mid_s_cyc", s_cyc, 32'd1);
      reset_n = 1'b0;
      tick();
      check_eq("mid_rst_grant", grant, 32'd0);
      check_eq("mid_rst_s_cyc", s_cyc, 32'd0);
      reset_n = 1'b1;
      tick();
      check_eq("mid_regrant", grant, 32'd2);
      set_m1(1'b0);
      tick();
      check_eq("mid_idle", grant, 32'd0);

`ifdef WB_ARB_TIMEOUT_EN
      // Slave never answers an m0 read; error on the 16th stalled cycle.
      m0_adr = 32'h3000_3000;
      set_m0(1'b1);
      tick();
      set_m1(1'b1);
      for (int k = 1; k < 16; k++) begin
         #1;
         check_eq("to_wait_err", m0_err, 32'd0);
         check_eq("to_wait_cyc", s_cyc, 32'd1);
         tick();
      end
      #1;
      check_eq("to_m0_err", m0_err, 32'd1);
      check_eq("to_s_cyc", s_cyc, 32'd0);
      check_eq("to_s_stb", s_stb, 32'd0);
      check_eq("to_m1_err", m1_err, 32'd0);
      set_m0(1'b0);
      tick();
      check_eq("to_err_1cyc", m0_err, 32'd0);
      check_eq("to_gap", grant, 32'd0);
      tick();
      check_eq("to_m1_grant", grant, 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
